multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 82 ++++++++
 rtl/alu_decode.sv | 22 ++
 rtl/multicycle_ctrl.sv | 157 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, function codes,
// ALU operations, mux selects and FSM states.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_WB_R    = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_WB_MEM  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_BR      = 4'd8,
    S_EX_I    = 4'd9,
    S_WB_I    = 4'd10,
    S_JMP     = 4'd11,
    S_JR      = 4'd12,
    S_JAL     = 4'd13
  } state_t;

  // Which ALU behaviour a state asks for; alu_decode resolves it to an op.
  typedef enum logic [1:0] {
    AC_ADD   = 2'd0,
    AC_SUB   = 2'd1,
    AC_FUNCT = 2'd2,
    AC_IMM   = 2'd3
  } alu_class_t;

  function automatic alu_op_t funct_to_aluop(input logic [5:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU operation select from the state's ALU class and the
// instruction's opcode/function fields.
module alu_decode
  import mc_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  Insto,
  input  logic [5:0]  Funct,
  output logic [2:0]  ALUop
);

  always_comb begin
    ALUop = ALU_ADD;
    case (alu_class)
      AC_SUB:   ALUop = ALU_SUB;
      AC_FUNCT: ALUop = funct_to_aluop(Funct);
      AC_IMM:   ALUop = (Insto == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default:  ALUop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath, with a counter of
// retired instructions.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Insto,
  input  logic [5:0]       Funct,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [2:0]       ALUop,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q;
  alu_class_t alu_class;
  logic       last_step;

  assign state = state_q;

  // Every state other than these leads straight back to IF, so leaving it
  // completes an instruction; ID->IF (illegal opcode) is excluded here.
  always_comb begin
    case (state_q)
      S_IF, S_ID, S_EX_R, S_MEM_ADR, S_MEM_RD, S_EX_I: last_step = 1'b0;
      default:                                         last_step = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      retired <= '0;
    end else begin
      if (last_step) retired <= retired + 1'b1;
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          case (Insto)
            OP_RTYPE:     state_q <= (Funct == FN_JR) ? S_JR : S_EX_R;
            OP_LW, OP_SW: state_q <= S_MEM_ADR;
            OP_BEQ:       state_q <= S_BR;
            OP_ADDI,
            OP_SLTI:      state_q <= S_EX_I;
            OP_J:         state_q <= S_JMP;
            OP_JAL:       state_q <= S_JAL;
            default:      state_q <= S_IF;
          endcase
        end
        S_EX_R:    state_q <= S_WB_R;
        S_MEM_ADR: state_q <= (Insto == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_q <= S_WB_MEM;
        S_EX_I:    state_q <= S_WB_I;
        default:   state_q <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    PCSrc       = PC_ALU;
    RegDst      = DST_RT;
    MemtoReg    = WB_ALUOUT;
    alu_class   = AC_ADD;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
      end
      S_ID: ALUSrcB = SRCB_IMM_SH;
      S_EX_R: begin
        ALUSrcA   = 1'b1;
        alu_class = AC_FUNCT;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = DST_RD;
      end
      S_MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = WB_MDR;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSrc       = PC_ALUOUT;
        alu_class   = AC_SUB;
      end
      S_EX_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        alu_class = AC_IMM;
      end
      S_WB_I: RegWrite = 1'b1;
      S_JMP: begin
        PCWrite = 1'b1;
        PCSrc   = PC_JUMP;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = PC_REGA;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = PC_JUMP;
        RegWrite = 1'b1;
        RegDst   = DST_RA;
        MemtoReg = WB_PC;
      end
      default: ;
    endcase
  end

  alu_decode u_alu_decode (
    .alu_class (alu_class),
    .Insto     (Insto),
    .Funct     (Funct),
    .ALUop     (ALUop)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed sequences plus random
// instruction streams checked against a per-instruction behavioural model.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Insto = '0;
  logic [5:0] Funct = '0;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc, RegDst, MemtoReg;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic [15:0] retired;

  logic       b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_RegWrite, b_ALUSrcA;
  logic [1:0] b_ALUSrcB, b_PCSrc, b_RegDst, b_MemtoReg;
  logic [2:0] b_ALUop;
  logic [3:0] b_state;
  logic [1:0] b_retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .Insto(Insto), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUop(ALUop), .state(state), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .Insto(Insto), .Funct(Funct),
    .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD), .MemRead(b_MemRead),
    .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA),
    .ALUSrcB(b_ALUSrcB), .PCSrc(b_PCSrc), .RegDst(b_RegDst), .MemtoReg(b_MemtoReg),
    .ALUop(b_ALUop), .state(b_state), .retired(b_retired)
  );

  // All control outputs in one vector: 8 single bits, 4 two-bit selects, ALUop.
  logic [18:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                ALUSrcB, PCSrc, RegDst, MemtoReg, ALUop};
  localparam logic [18:0] CTL_IF = {8'b1001_0100, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000};

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if (state !== S_IF) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IF); end
    total++;
    if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    total++;
    if (ctl !== CTL_IF) begin bad++; $display("FAIL reset_if_outputs got=%b exp=%b", ctl, CTL_IF); end
  endtask

  task automatic test_lw;
    state_t seq[6] = '{S_IF, S_ID, S_MEM_ADR, S_MEM_RD, S_WB_MEM, S_IF};
    do_reset();
    Insto = OP_LW; Funct = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (state !== seq[i]) begin bad++; $display("FAIL lw_seq[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      if (i == 3) begin
        total++;
        if (MemRead !== 1'b1 || IorD !== 1'b1) begin
          bad++; $display("FAIL lw_memrd got=%b%b exp=11", MemRead, IorD);
        end
      end
      if (i < 5) @(negedge clk);
    end
    total++;
    if (retired !== 16'd1) begin bad++; $display("FAIL lw_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_sub;
    Insto = OP_RTYPE; Funct = FN_SUB;
    repeat (2) @(negedge clk);
    total++;
    if (state !== S_EX_R || ALUop !== 3'b001 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin
      bad++; $display("FAIL sub_exr state=%0d aluop=%b srca=%b srcb=%b exp=2 001 1 00", state, ALUop, ALUSrcA, ALUSrcB);
    end
    @(negedge clk);
    total++;
    if (state !== S_WB_R || RegWrite !== 1'b1 || RegDst !== 2'b01 || MemtoReg !== 2'b00) begin
      bad++; $display("FAIL sub_wbr state=%0d rw=%b dst=%b m2r=%b exp=3 1 01 00", state, RegWrite, RegDst, MemtoReg);
    end
    @(negedge clk);
    total++;
    if (state !== S_IF) begin bad++; $display("FAIL sub_back_if got=%0d exp=0", state); end
  endtask

  task automatic test_beq;
    Insto = OP_BEQ;
    repeat (2) @(negedge clk);
    total++;
    if (state !== S_BR || PCWriteCond !== 1'b1 || PCSrc !== 2'b01 || ALUop !== 3'b001 || PCWrite !== 1'b0) begin
      bad++; $display("FAIL beq_br state=%0d pwc=%b pcsrc=%b aluop=%b pcw=%b exp=8 1 01 001 0", state, PCWriteCond, PCSrc, ALUop, PCWrite);
    end
    @(negedge clk);
    total++;
    if (state !== S_IF) begin bad++; $display("FAIL beq_back_if got=%0d exp=0", state); end
  endtask

  task automatic test_jal_jr;
    Insto = OP_JAL;
    repeat (2) @(negedge clk);
    total++;
    if (state !== S_JAL || PCWrite !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 2'b10 || MemtoReg !== 2'b10 || PCSrc !== 2'b10) begin
      bad++; $display("FAIL jal state=%0d pcw=%b rw=%b dst=%b m2r=%b pcsrc=%b exp=13 1 1 10 10 10", state, PCWrite, RegWrite, RegDst, MemtoReg, PCSrc);
    end
    @(negedge clk);
    Insto = OP_RTYPE; Funct = FN_JR;
    repeat (2) @(negedge clk);
    total++;
    if (state !== S_JR || PCWrite !== 1'b1 || PCSrc !== 2'b11 || RegWrite !== 1'b0) begin
      bad++; $display("FAIL jr state=%0d pcw=%b pcsrc=%b rw=%b exp=12 1 11 0", state, PCWrite, PCSrc, RegWrite);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    logic [15:0] r0;
    r0 = retired;
    Insto = 6'b111111;
    @(negedge clk);
    total++;
    if (state !== S_ID) begin bad++; $display("FAIL ill_id got=%0d exp=1", state); end
    @(negedge clk);
    total++;
    if (state !== S_IF || retired !== r0) begin
      bad++; $display("FAIL ill_back state=%0d retired=%0d exp=0 %0d", state, retired, r0);
    end
  endtask

  task automatic test_reset_mid;
    Insto = OP_J;
    repeat (3) @(negedge clk);
    Insto = OP_SW;
    repeat (3) @(negedge clk);
    total++;
    if (state !== S_MEM_WR || MemWrite !== 1'b1 || retired === 16'd0) begin
      bad++; $display("FAIL rmid_memwr state=%0d mw=%b retired=%0d exp=7 1 nonzero", state, MemWrite, retired);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (state !== S_IF || MemWrite !== 1'b0 || retired !== 16'd0 || ctl !== CTL_IF) begin
      bad++; $display("FAIL rmid_after state=%0d mw=%b retired=%0d ctl=%b exp=0 0 0 %b", state, MemWrite, retired, ctl, CTL_IF);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    Insto = OP_J;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge clk);
      total++;
      if (b_retired !== 2'((k + 1) % 4)) begin
        bad++; $display("FAIL wrap[%0d] got=%0d exp=%0d", k, b_retired, (k + 1) % 4);
      end
    end
    total++;
    if (retired !== 16'd5) begin bad++; $display("FAIL wrap_wide got=%0d exp=5", retired); end
  endtask

  task automatic test_random;
    logic [5:0] ops[10];
    logic [5:0] fns[8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b001010, 6'b000010, 6'b000011, 6'b111111, 6'b010101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
            6'b001000, 6'b000000, 6'b110011};
    do_reset();
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op, fn;
      int e_lat, e_ret, e_rw, e_mw, e_mr, e_ex, e_pcw, e_cond;
      logic [1:0] e_dst, e_m2r, e_pcsrc;
      logic [2:0] e_alu;
      int cyc, n_rw, n_mw, n_mr, n_ex, n_pcw, n_cond;
      logic [1:0] g_dst, g_m2r, g_pcsrc, g_csrc;
      logic [2:0] g_alu;
      logic [15:0] r0;
      op = ops[$urandom_range(0, 9)];
      fn = fns[$urandom_range(0, 7)];
      e_lat = 2; e_ret = 0; e_rw = 0; e_mw = 0; e_mr = 1; e_ex = 0; e_pcw = 1; e_cond = 0;
      e_dst = 2'b00; e_m2r = 2'b00; e_pcsrc = 2'b00; e_alu = 3'b000;
      case (op)
        6'b000000: begin
          if (fn == 6'b001000) begin e_lat = 3; e_pcw = 2; e_pcsrc = 2'b11; end
          else begin
            e_lat = 4; e_rw = 1; e_dst = 2'b01; e_ex = 1;
            case (fn)
              6'b100010: e_alu = 3'b001;
              6'b100100: e_alu = 3'b010;
              6'b100101: e_alu = 3'b011;
              6'b101010: e_alu = 3'b100;
              default:   e_alu = 3'b000;
            endcase
          end
        end
        6'b100011: begin e_lat = 5; e_rw = 1; e_m2r = 2'b01; e_mr = 2; e_ex = 1; end
        6'b101011: begin e_lat = 4; e_mw = 1; e_ex = 1; end
        6'b000100: begin e_lat = 3; e_ex = 1; e_alu = 3'b001; e_cond = 1; end
        6'b001000: begin e_lat = 4; e_rw = 1; e_ex = 1; end
        6'b001010: begin e_lat = 4; e_rw = 1; e_ex = 1; e_alu = 3'b100; end
        6'b000010: begin e_lat = 3; e_pcw = 2; e_pcsrc = 2'b10; end
        6'b000011: begin e_lat = 3; e_pcw = 2; e_pcsrc = 2'b10; e_rw = 1; e_dst = 2'b10; e_m2r = 2'b10; end
        default: ;
      endcase
      if (e_lat != 2) e_ret = 1;

      Insto = op; Funct = fn;
      r0 = retired;
      cyc = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_ex = 0; n_pcw = 0; n_cond = 0;
      g_dst = 2'b00; g_m2r = 2'b00; g_pcsrc = 2'b00; g_csrc = 2'b00; g_alu = 3'b000;
      do begin
        if (RegWrite === 1'b1) begin n_rw++; g_dst = RegDst; g_m2r = MemtoReg; end
        if (MemWrite === 1'b1) n_mw++;
        if (MemRead === 1'b1) n_mr++;
        if (ALUSrcA === 1'b1) begin n_ex++; g_alu = ALUop; end
        if (PCWrite === 1'b1) begin n_pcw++; if (IRWrite !== 1'b1) g_pcsrc = PCSrc; end
        if (PCWriteCond === 1'b1) begin n_cond++; g_csrc = PCSrc; end
        @(negedge clk);
        cyc++;
      end while (state !== S_IF && cyc < 10);

      total++;
      if (cyc != e_lat) begin bad++; $display("FAIL rnd_lat op=%b fn=%b got=%0d exp=%0d", op, fn, cyc, e_lat); end
      total++;
      if (retired !== 16'(r0 + 16'(e_ret))) begin
        bad++; $display("FAIL rnd_retired op=%b got=%0d exp=%0d", op, retired, 16'(r0 + 16'(e_ret)));
      end
      total++;
      if (n_rw != e_rw || (e_rw == 1 && (g_dst !== e_dst || g_m2r !== e_m2r))) begin
        bad++; $display("FAIL rnd_regwrite op=%b got=%0d/%b/%b exp=%0d/%b/%b", op, n_rw, g_dst, g_m2r, e_rw, e_dst, e_m2r);
      end
      total++;
      if (n_mw != e_mw || n_mr != e_mr) begin
        bad++; $display("FAIL rnd_mem op=%b got=w%0d r%0d exp=w%0d r%0d", op, n_mw, n_mr, e_mw, e_mr);
      end
      total++;
      if (n_ex != e_ex || (e_ex == 1 && g_alu !== e_alu)) begin
        bad++; $display("FAIL rnd_alu op=%b fn=%b got=%0d/%b exp=%0d/%b", op, fn, n_ex, g_alu, e_ex, e_alu);
      end
      total++;
      if (n_pcw != e_pcw || (e_pcw == 2 && g_pcsrc !== e_pcsrc) || n_cond != e_cond || (e_cond == 1 && g_csrc !== 2'b01)) begin
        bad++; $display("FAIL rnd_pc op=%b got=%0d/%b c%0d/%b exp=%0d/%b c%0d/01", op, n_pcw, g_pcsrc, n_cond, g_csrc, e_pcw, e_pcsrc, e_cond);
      end
      if (state !== S_IF) begin
        bad++; $display("FAIL rnd_timeout op=%b state=%0d", op, state);
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

endmodule
